// File: rtl/mem_access_unit_if.sv
// Bundle of the upstream op handshake and the data-memory req/ack port.
// The slave view belongs to the memory-access stage; master is the ALU/memory side.
interface mem_access_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              in_valid;
  logic              in_ready;
  logic              isld;
  logic              isst;
  logic [1:0]        size;
  logic              ld_signed;
  logic [ADDR_W-1:0] aluresult;
  logic [DATA_W-1:0] op2;
  logic              out_valid;
  logic [DATA_W-1:0] ldresult;
  logic              misalign;
  logic              timeout;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output in_valid, isld, isst, size, ld_signed, aluresult, op2, mem_ack, mem_rdata,
    input  in_ready, out_valid, ldresult, misalign, timeout,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    input  in_valid, isld, isst, size, ld_signed, aluresult, op2, mem_ack, mem_rdata,
    output in_ready, out_valid, ldresult, misalign, timeout,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-access pipeline stage: one ld/st per handshake, byte-lane steering,
// load extension, bypass for non-memory ops, misalignment and ack-timeout reporting.
module mem_access_unit #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input logic              clk,
  input logic              rst_n,
  mem_access_unit_if.slave bus
);
  localparam int BE_W   = DATA_W / 8;
  localparam int LANE_W = $clog2(BE_W);
  localparam int CNT_W  = 8;

  typedef enum logic {IDLE, REQ} state_t;

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [1:0]        size_reg;
  logic              signed_reg;
  logic [LANE_W-1:0] lane_reg;
  logic              out_valid_reg;
  logic              misalign_reg;
  logic              timeout_reg;
  logic              mem_req_reg;
  logic              mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [BE_W-1:0]   mem_be_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
  logic [DATA_W-1:0] ldresult_reg;

  logic [LANE_W-1:0] lane;
  logic              is_mem;
  logic              aligned;
  logic [BE_W-1:0]   be_next;
  logic [DATA_W-1:0] wdata_next;
  logic [DATA_W-1:0] rdata_shifted;
  logic [DATA_W-1:0] keep_mask;
  logic              sign_bit;
  logic [DATA_W-1:0] ld_ext;

  assign lane   = bus.aluresult[LANE_W-1:0];
  assign is_mem = bus.isld || bus.isst;

  always_comb begin
    aligned = 1'b1;
    case (bus.size)
      2'b01:   aligned = ~bus.aluresult[0];
      2'b10:   aligned = (bus.aluresult[1:0] == 2'b00);
      2'b11:   aligned = (DATA_W == 64) && (bus.aluresult[2:0] == 3'b000);
      default: aligned = 1'b1;
    endcase
  end

  // Per-lane enable and write data: a lane is enabled when it shares the access's
  // naturally aligned container; its data comes from the matching byte of op2.
  genvar gi;
  generate
    for (gi = 0; gi < BE_W; gi++) begin : g_lane
      assign be_next[gi] =
          (bus.size == 2'b00) ? (int'(lane) == gi) :
          (bus.size == 2'b01) ? ((int'(lane) >> 1) == (gi >> 1)) :
          (bus.size == 2'b10) ? ((int'(lane) >> 2) == (gi >> 2)) : 1'b1;
      assign wdata_next[8*gi +: 8] =
          (bus.size == 2'b00) ? bus.op2[7:0] :
          (bus.size == 2'b01) ? bus.op2[8*(gi%2) +: 8] :
          (bus.size == 2'b10) ? bus.op2[8*(gi%4) +: 8] : bus.op2[8*gi +: 8];
    end
  endgenerate

  assign rdata_shifted = bus.mem_rdata >> {lane_reg, 3'b000};

  always_comb begin
    keep_mask = '1;
    sign_bit  = 1'b0;
    case (size_reg)
      2'b00: begin
        keep_mask = DATA_W'(8'hFF);
        sign_bit  = rdata_shifted[7];
      end
      2'b01: begin
        keep_mask = DATA_W'(16'hFFFF);
        sign_bit  = rdata_shifted[15];
      end
      2'b10: begin
        keep_mask = DATA_W'(32'hFFFF_FFFF);
        sign_bit  = rdata_shifted[31];
      end
      default: begin
        keep_mask = '1;
        sign_bit  = rdata_shifted[DATA_W-1];
      end
    endcase
    ld_ext = (rdata_shifted & keep_mask) | ((signed_reg && sign_bit) ? ~keep_mask : '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      size_reg      <= 2'b00;
      signed_reg    <= 1'b0;
      lane_reg      <= '0;
      out_valid_reg <= 1'b0;
      misalign_reg  <= 1'b0;
      timeout_reg   <= 1'b0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_be_reg    <= '0;
      mem_wdata_reg <= '0;
      ldresult_reg  <= '0;
    end else begin
      out_valid_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (!is_mem) begin
              out_valid_reg <= 1'b1;
              misalign_reg  <= 1'b0;
              timeout_reg   <= 1'b0;
              ldresult_reg  <= DATA_W'(bus.aluresult);
            end else if (!aligned) begin
              out_valid_reg <= 1'b1;
              misalign_reg  <= 1'b1;
              timeout_reg   <= 1'b0;
              ldresult_reg  <= '0;
            end else begin
              // A store with isld also high is demoted to a load.
              state         <= REQ;
              wait_cnt      <= '0;
              size_reg      <= bus.size;
              signed_reg    <= bus.ld_signed;
              lane_reg      <= lane;
              mem_req_reg   <= 1'b1;
              mem_we_reg    <= bus.isst && !bus.isld;
              mem_addr_reg  <= {bus.aluresult[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
              mem_be_reg    <= be_next;
              mem_wdata_reg <= wdata_next;
            end
          end
        end
        REQ: begin
          // An ack in the final allowed cycle still counts as a normal completion.
          if (bus.mem_ack) begin
            state         <= IDLE;
            mem_req_reg   <= 1'b0;
            out_valid_reg <= 1'b1;
            misalign_reg  <= 1'b0;
            timeout_reg   <= 1'b0;
            ldresult_reg  <= mem_we_reg ? '0 : ld_ext;
          end else if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
            state         <= IDLE;
            wait_cnt      <= wait_cnt + 1'b1;
            mem_req_reg   <= 1'b0;
            out_valid_reg <= 1'b1;
            misalign_reg  <= 1'b0;
            timeout_reg   <= 1'b1;
            ldresult_reg  <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_reg;
  assign bus.ldresult  = ldresult_reg;
  assign bus.misalign  = misalign_reg;
  assign bus.timeout   = timeout_reg;
  assign bus.mem_req   = mem_req_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_be    = mem_be_reg;
  assign bus.mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized ops
// compared against an arithmetic byte-lane reference model.
module tb_mem_access_unit;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 32;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  mem_access_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mem_access_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Observations from the most recent transaction.
  int          r_lat;
  int          r_reqs;
  int          r_ov_cyc;
  int          r_stable_err;
  int          r_ready_err;
  logic [31:0] r_ld;
  logic        r_mis;
  logic        r_to;
  logic        r_ready;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic        r_we;

  // Reference model: plain arithmetic on byte counts and offsets.
  function automatic bit m_legal(input logic [1:0] sz, input logic [31:0] a);
    return (sz != 2'd3) && ((a % (32'd1 << sz)) == 0);
  endfunction

  function automatic logic [63:0] m_mask(input logic [1:0] sz);
    return (64'd1 << (8 * (1 << sz))) - 64'd1;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    int n = 1 << sz;
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
    int          n = 1 << sz;
    logic [63:0] v = {32'd0, d} & m_mask(sz);
    logic [63:0] r = 64'd0;
    for (int k = 0; k < 4 / n; k++) r = r | (v << (8 * n * k));
    return r[31:0];
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic sgn,
                                         input logic [31:0] a, input logic [31:0] rd);
    int          n = 1 << sz;
    logic [63:0] v = ({32'd0, rd} >> (8 * (a % 4))) & m_mask(sz);
    if (sgn && v[8*n-1]) v = v | ~m_mask(sz);
    return v[31:0];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs;
    bus.in_valid  = 1'b0;
    bus.isld      = 1'b0;
    bus.isst      = 1'b0;
    bus.size      = 2'b00;
    bus.ld_signed = 1'b0;
    bus.aluresult = '0;
    bus.op2       = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
  endtask

  // Presents one op, plays the memory (ack after 'waits' unacked REQ cycles, never if
  // waits < 0) and returns at the out_valid cycle without advancing past it.
  task automatic do_op(input logic ld, input logic st, input logic [1:0] sz,
                       input logic sgn, input logic [31:0] addr, input logic [31:0] d,
                       input int waits, input logic [31:0] rdata);
    int reqs = 0;
    bit done = 0;
    r_lat = -1; r_stable_err = 0; r_ready_err = 0;
    r_addr = '0; r_be = '0; r_wdata = '0; r_we = 1'b0;
    r_ld = '0; r_mis = 1'b0; r_to = 1'b0; r_ready = 1'b0; r_ov_cyc = -1;
    bus.in_valid = 1'b1; bus.isld = ld; bus.isst = st; bus.size = sz;
    bus.ld_signed = sgn; bus.aluresult = addr; bus.op2 = d;
    tick();
    bus.in_valid = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      bus.mem_ack = 1'b0;
      if (bus.mem_req) begin
        if (reqs == 0) begin
          r_addr = bus.mem_addr; r_be = bus.mem_be; r_wdata = bus.mem_wdata; r_we = bus.mem_we;
        end else if (bus.mem_addr !== r_addr || bus.mem_be !== r_be ||
                     bus.mem_wdata !== r_wdata || bus.mem_we !== r_we) begin
          r_stable_err++;
        end
        if (bus.in_ready !== 1'b0) r_ready_err++;
        reqs++;
        if (reqs - 1 == waits) begin
          bus.mem_ack = 1'b1;
          bus.mem_rdata = rdata;
        end
      end
      if (bus.out_valid === 1'b1) begin
        r_lat = c; r_ld = bus.ldresult; r_mis = bus.misalign; r_to = bus.timeout;
        r_ready = bus.in_ready; r_ov_cyc = cyc; done = 1;
      end else begin
        tick();
      end
    end
    bus.mem_ack = 1'b0;
    r_reqs = reqs;
    $display("op ld=%0d st=%0d size=%0d sgn=%0d addr=%h waits=%0d -> lat=%0d reqs=%0d ldresult=%h mis=%0d to=%0d",
             ld, st, sz, sgn, addr, waits, r_lat, r_reqs, r_ld, r_mis, r_to);
  endtask

  task automatic test_reset;
    logic [31:0] seen;
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if ({bus.out_valid, bus.misalign, bus.timeout, bus.mem_req, bus.mem_we, bus.mem_be,
         bus.ldresult, bus.mem_addr, bus.mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got out_valid=%b req=%b be=%h ld=%h addr=%h wdata=%h, want all 0",
               bus.out_valid, bus.mem_req, bus.mem_be, bus.ldresult, bus.mem_addr, bus.mem_wdata);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    // Abort a request mid-flight.
    bus.in_valid = 1'b1; bus.isld = 1'b1; bus.size = 2'b10; bus.aluresult = 32'h40;
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.mem_req !== 1'b1) begin
      errors++; $display("FAIL reset_req_started: got mem_req=%b want 1", bus.mem_req);
    end
    tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({bus.mem_req, bus.out_valid, bus.mem_we, bus.mem_be, bus.mem_addr, bus.ldresult} !== '0) begin
      errors++;
      $display("FAIL reset_abort: got mem_req=%b out_valid=%b addr=%h be=%h, want all 0",
               bus.mem_req, bus.out_valid, bus.mem_addr, bus.mem_be);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b want 1", bus.in_ready);
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = $urandom;
    tick();
    bus.mem_ack = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.out_valid !== 1'b0) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL reset_late_ack: got %0d out_valid cycles want 0", seen);
    end
    idle_inputs();
  endtask

  task automatic test_store_byte;
    do_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h1003, 32'hAABBCCDD, 3, 32'h0);
    checks++;
    if (r_addr !== 32'h1000 || r_be !== 4'b1000 || r_we !== 1'b1) begin
      errors++; $display("FAIL store_byte_bus: got addr=%h be=%b we=%b want 1000 1000 1", r_addr, r_be, r_we);
    end
    checks++;
    if (r_wdata !== 32'hDDDDDDDD) begin
      errors++; $display("FAIL store_byte_wdata: got %h want DDDDDDDD", r_wdata);
    end
    checks++;
    if (r_lat !== 5 || r_reqs !== 4 || r_mis !== 1'b0 || r_to !== 1'b0) begin
      errors++; $display("FAIL store_byte_timing: got lat=%0d reqs=%0d mis=%b to=%b want 5 4 0 0", r_lat, r_reqs, r_mis, r_to);
    end
    checks++;
    if (r_stable_err !== 0 || r_ready_err !== 0 || r_ready !== 1'b1) begin
      errors++; $display("FAIL store_byte_stable: got unstable=%0d ready_in_req=%0d ready_at_done=%b want 0 0 1",
                         r_stable_err, r_ready_err, r_ready);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL store_byte_pulse: got out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_load_extend;
    do_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h2002, 32'h0, int'($urandom_range(0, 2)), 32'h8001_7FFF);
    checks++;
    if (r_ld !== 32'hFFFF8001 || r_be !== 4'b1100 || r_we !== 1'b0 || r_addr !== 32'h2000) begin
      errors++; $display("FAIL load_half_signed: got ld=%h be=%b we=%b addr=%h want FFFF8001 1100 0 2000", r_ld, r_be, r_we, r_addr);
    end
    tick();
    do_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h2002, 32'h0, int'($urandom_range(0, 2)), 32'h8001_7FFF);
    checks++;
    if (r_ld !== 32'h00008001) begin
      errors++; $display("FAIL load_half_unsigned: got %h want 00008001", r_ld);
    end
    tick();
    do_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h2001, 32'h0, int'($urandom_range(0, 2)), 32'h0000_8000);
    checks++;
    if (r_ld !== 32'hFFFFFF80 || r_be !== 4'b0010) begin
      errors++; $display("FAIL load_byte_signed: got ld=%h be=%b want FFFFFF80 0010", r_ld, r_be);
    end
    tick();
  endtask

  task automatic test_misalign;
    do_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h3001, 32'h0, 0, $urandom);
    checks++;
    if (r_reqs !== 0 || r_lat !== 1 || r_mis !== 1'b1 || r_ld !== 32'h0 || r_to !== 1'b0) begin
      errors++; $display("FAIL misalign_word: got reqs=%0d lat=%0d mis=%b ld=%h to=%b want 0 1 1 0 0", r_reqs, r_lat, r_mis, r_ld, r_to);
    end
    do_op(1'b0, 1'b1, 2'b11, 1'b0, 32'h3008, $urandom, 0, 32'h0);
    checks++;
    if (r_reqs !== 0 || r_lat !== 1 || r_mis !== 1'b1) begin
      errors++; $display("FAIL misalign_dword: got reqs=%0d lat=%0d mis=%b want 0 1 1", r_reqs, r_lat, r_mis);
    end
    tick();
  endtask

  task automatic test_timeout;
    logic [31:0] rd;
    do_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, -1, 32'h0);
    checks++;
    if (r_reqs !== MAX_WAIT || r_lat !== MAX_WAIT + 1 || r_to !== 1'b1 || r_ld !== 32'h0 || r_mis !== 1'b0) begin
      errors++; $display("FAIL timeout_noack: got reqs=%0d lat=%0d to=%b ld=%h want %0d %0d 1 0",
                         r_reqs, r_lat, r_to, r_ld, MAX_WAIT, MAX_WAIT + 1);
    end
    tick();
    rd = $urandom;
    do_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h404, 32'h0, MAX_WAIT - 1, rd);
    checks++;
    if (r_reqs !== MAX_WAIT || r_lat !== MAX_WAIT + 1 || r_to !== 1'b0 || r_ld !== rd) begin
      errors++; $display("FAIL timeout_last_ack: got reqs=%0d lat=%0d to=%b ld=%h want %0d %0d 0 %h",
                         r_reqs, r_lat, r_to, r_ld, MAX_WAIT, MAX_WAIT + 1, rd);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    int          c1;
    logic [31:0] rd1, rd2;
    do_op(1'b0, 1'b0, 2'b10, 1'b0, 32'h1234, 32'h0, 0, 32'h0);
    checks++;
    if (r_ld !== 32'h1234 || r_lat !== 1 || r_reqs !== 0 || r_mis !== 1'b0) begin
      errors++; $display("FAIL bypass: got ld=%h lat=%0d reqs=%0d mis=%b want 1234 1 0 0", r_ld, r_lat, r_reqs, r_mis);
    end
    rd1 = $urandom; rd2 = $urandom;
    do_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h500, 32'h0, 0, rd1);
    c1 = r_ov_cyc;
    checks++;
    if (r_lat !== 2 || r_ld !== rd1) begin
      errors++; $display("FAIL b2b_first: got lat=%0d ld=%h want 2 %h", r_lat, r_ld, rd1);
    end
    do_op(1'b1, 1'b1, 2'b10, 1'b0, 32'h504, 32'h0, 0, rd2);
    checks++;
    if (r_lat !== 2 || r_ld !== rd2 || r_we !== 1'b0 || (r_ov_cyc - c1) !== 2) begin
      errors++; $display("FAIL b2b_second: got lat=%0d ld=%h we=%b spacing=%0d want 2 %h 0 2",
                         r_lat, r_ld, r_we, r_ov_cyc - c1, rd2);
    end
    tick();
  endtask

  task automatic test_random;
    for (int n = 0; n < 60; n++) begin
      int          sel   = int'($urandom_range(0, 4));
      logic        ld    = (sel == 2 || sel == 3 || sel == 4);
      logic        st    = (sel == 1 || sel == 3);
      logic [1:0]  sz    = 2'($urandom_range(0, 3));
      logic        sgn   = 1'($urandom_range(0, 1));
      logic [31:0] addr  = $urandom_range(0, 255);
      logic [31:0] d     = $urandom;
      logic [31:0] rd    = $urandom;
      int          waits = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 5));
      do_op(ld, st, sz, sgn, addr, d, waits, rd);
      checks++;
      if (!(ld || st)) begin
        if (r_lat !== 1 || r_reqs !== 0 || r_ld !== addr || r_mis !== 1'b0 || r_to !== 1'b0) begin
          errors++; $display("FAIL rand_bypass #%0d: got lat=%0d reqs=%0d ld=%h mis=%b to=%b want 1 0 %h 0 0",
                             n, r_lat, r_reqs, r_ld, r_mis, r_to, addr);
        end
      end else if (!m_legal(sz, addr)) begin
        if (r_lat !== 1 || r_reqs !== 0 || r_ld !== 32'h0 || r_mis !== 1'b1 || r_to !== 1'b0) begin
          errors++; $display("FAIL rand_misalign #%0d: got lat=%0d reqs=%0d ld=%h mis=%b to=%b want 1 0 0 1 0",
                             n, r_lat, r_reqs, r_ld, r_mis, r_to);
        end
      end else if (waits < 0 || waits >= MAX_WAIT) begin
        if (r_lat !== MAX_WAIT + 1 || r_reqs !== MAX_WAIT || r_ld !== 32'h0 || r_to !== 1'b1 || r_mis !== 1'b0) begin
          errors++; $display("FAIL rand_timeout #%0d: got lat=%0d reqs=%0d ld=%h to=%b mis=%b want %0d %0d 0 1 0",
                             n, r_lat, r_reqs, r_ld, r_to, r_mis, MAX_WAIT + 1, MAX_WAIT);
        end
      end else begin
        if (r_lat !== waits + 2 || r_reqs !== waits + 1 || r_to !== 1'b0 || r_mis !== 1'b0 ||
            r_addr !== (addr & ~32'd3) || r_be !== m_be(sz, addr) || r_we !== (st && !ld) ||
            r_stable_err !== 0 || (ld && r_ld !== m_load(sz, sgn, addr, rd)) ||
            (!ld && r_wdata !== m_wdata(sz, d))) begin
          errors++; $display("FAIL rand_access #%0d: got lat=%0d addr=%h be=%b we=%b wdata=%h ld=%h to=%b want %0d %h %b %b %h %h 0",
                             n, r_lat, r_addr, r_be, r_we, r_wdata, r_ld, r_to, waits + 2, addr & ~32'd3,
                             m_be(sz, addr), st && !ld, m_wdata(sz, d), m_load(sz, sgn, addr, rd));
        end
      end
      if ($urandom_range(0, 1) == 1) tick();
    end
    tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_store_byte();
    test_load_extend();
    test_misalign();
    test_timeout();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
